// File: rtl/sd_card_responder_pkg.sv
// Shared definitions for the SPI-mode SD card responder: command indices,
// R1 bit masks, data tokens, FSM state encodings and the decode record.
package sd_card_responder_pkg;

  // Command indices (low 6 bits of the first command byte)
  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
  localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
  localparam logic [5:0] CMD_SD_OP_COND   = 6'd41;
  localparam logic [5:0] CMD_APP_CMD      = 6'd55;

  // R1 bit masks and link bytes
  localparam logic [7:0] R1_IDLE     = 8'h01;
  localparam logic [7:0] R1_ILLEGAL  = 8'h04;
  localparam logic [7:0] R1_PARAM    = 8'h40;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam logic [7:0] CRC_BYTE    = 8'h00;

  localparam int unsigned BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    LINK_HUNT,
    LINK_CMD,
    LINK_NCR,
    LINK_RESP,
    LINK_NAC,
    LINK_TOKEN,
    LINK_DATA,
    LINK_CRC
  } link_state_e;

  typedef enum logic [1:0] {
    CARD_POWERUP,
    CARD_IDLE,
    CARD_READY
  } card_state_e;

  // Outcome of decoding one complete command frame
  typedef struct packed {
    logic        respond;  // 0: stay silent and return to HUNT
    logic [7:0]  r1;
    logic        r7;       // append the four CMD8 echo bytes
    logic        read;     // start a sector read after R1
    card_state_e card;
    logic        app;
    logic [7:0]  poll;
    logic        ready;
  } cmd_decode_t;

  // R1 reflecting only the card state (idle bit until init completes)
  function automatic logic [7:0] card_r1(input card_state_e state);
    return (state == CARD_READY) ? 8'h00 : R1_IDLE;
  endfunction

endpackage

// File: rtl/sd_card_responder_if.sv
// SPI link and backing-store bus of the card emulator. The master side is
// the host plus memory, the slave side is the emulated card.
interface sd_card_responder_if;
  logic        spi_cs;
  logic        spi_clk;
  logic        spi_di;
  logic        spi_do;
  logic [23:0] mem_address;
  logic [7:0]  mem_data;

  modport master (
    output spi_cs, spi_clk, spi_di, mem_data,
    input  spi_do, mem_address
  );

  modport slave (
    input  spi_cs, spi_clk, spi_di, mem_data,
    output spi_do, mem_address
  );
endinterface

// File: rtl/sd_card_responder_spi_byte_slave.sv
// SPI mode-0 byte slave running on the system clock: synchronises the pins,
// detects spi_clk edges, shifts MOSI in on rising edges and MISO out on
// falling edges. One rx_valid pulse per received byte; tx_byte is taken on
// the falling edge that follows that byte's 8th rising edge.
module spi_byte_slave (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic       spi_di,
  output logic       spi_do,
  output logic       cs_idle,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic [7:0] tx_byte
);

  logic       cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
  logic       sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       di_meta_q, di_meta_d, di_sync_q, di_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       do_q, do_d;
  logic       load_q, load_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       sclk_rise, sclk_fall;

  // Edge detect on the synchronised SPI clock
  always_comb begin
    sclk_rise = sclk_sync_q & ~sclk_prev_q;
    sclk_fall = ~sclk_sync_q & sclk_prev_q;
  end

  // Synchronisers, bit counter and shift registers; CS high wins over edges
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned and no latch is inferred.
    cs_meta_d   = spi_cs;
    cs_sync_d   = cs_meta_q;
    sclk_meta_d = spi_clk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    di_meta_d   = spi_di;
    di_sync_d   = di_meta_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    do_d        = do_q;
    load_d      = load_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;

    if (cs_sync_q) begin
      bit_cnt_d  = 3'd0;
      tx_shift_d = 8'hFF;
      do_d       = 1'b1;
      load_d     = 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[6:0], di_sync_q};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = {rx_shift_q[6:0], di_sync_q};
          load_d     = 1'b1;
        end
      end
      if (sclk_fall) begin
        if (load_q) begin
          do_d       = tx_byte[7];
          tx_shift_d = {tx_byte[6:0], 1'b1};
          load_d     = 1'b0;
        end else begin
          do_d       = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      di_meta_q   <= 1'b1;
      di_sync_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'hFF;
      do_q        <= 1'b1;
      load_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, like real hardware.
      cs_meta_q   <= cs_meta_d;
      cs_sync_q   <= cs_sync_d;
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      di_meta_q   <= di_meta_d;
      di_sync_q   <= di_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      do_q        <= do_d;
      load_q      <= load_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
    end
  end

  assign spi_do   = do_q;
  assign cs_idle  = cs_sync_q;
  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;

endmodule

// File: rtl/sd_card_responder.sv
// SPI-mode SD card emulator top: link FSM (command framing and response
// slots), card FSM (POWERUP/IDLE/READY) and sector-read memory addressing.
module sd_card_responder
  import sd_card_responder_pkg::*;
#(
  parameter int unsigned INIT_POLLS   = 2,
  parameter int unsigned ACCESS_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  sd_card_responder_if.slave       bus,
  output logic                     card_ready,
  output logic [7:0]               load_count
);

  logic        cs_idle, rx_valid;
  logic [7:0]  rx_byte;

  link_state_e link_q, link_d;
  card_state_e card_q, card_d;
  logic        app_q, app_d;
  logic [7:0]  poll_q, poll_d;
  logic        ready_q, ready_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic        read_q, read_d;
  logic [7:0]  tx_q, tx_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  load_cnt_q, load_cnt_d;

  cmd_decode_t dec;
  logic [7:0]  poll_inc;

  spi_byte_slave u_spi (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (bus.spi_cs),
    .spi_clk  (bus.spi_clk),
    .spi_di   (bus.spi_di),
    .spi_do   (bus.spi_do),
    .cs_idle  (cs_idle),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_byte  (tx_q)
  );

  // Decode the collected command against the current card state
  always_comb begin
    poll_inc    = poll_q + 8'd1;
    dec         = '0;
    dec.respond = 1'b1;
    dec.r1      = card_r1(card_q);
    dec.card    = card_q;
    dec.poll    = poll_q;
    dec.ready   = ready_q;
    dec.app     = 1'b0;

    if (card_q == CARD_POWERUP && cmd_q != CMD_GO_IDLE) begin
      dec.respond = 1'b0;
      dec.app     = app_q;
    end else begin
      case (cmd_q)
        CMD_GO_IDLE: begin
          dec.card  = CARD_IDLE;
          dec.poll  = 8'd0;
          dec.ready = 1'b0;
          dec.r1    = R1_IDLE;
        end
        CMD_SEND_IF_COND: dec.r7 = 1'b1;
        CMD_APP_CMD:      dec.app = 1'b1;
        CMD_SD_OP_COND: begin
          if (!app_q) begin
            dec.r1 = card_r1(card_q) | R1_ILLEGAL;
          end else if (card_q == CARD_IDLE) begin
            dec.poll = poll_inc;
            if (32'(poll_inc) >= INIT_POLLS) begin
              dec.r1    = 8'h00;
              dec.card  = CARD_READY;
              dec.ready = 1'b1;
            end else begin
              dec.r1 = R1_IDLE;
            end
          end else begin
            dec.r1 = 8'h00;
          end
        end
        CMD_READ_SINGLE: begin
          if (card_q != CARD_READY) begin
            dec.r1 = card_r1(card_q) | R1_ILLEGAL;
          end else if (arg_q[31:15] != 17'd0) begin
            dec.r1 = R1_PARAM;
          end else begin
            dec.r1   = 8'h00;
            dec.read = 1'b1;
          end
        end
        default: dec.r1 = card_r1(card_q) | R1_ILLEGAL;
      endcase
    end
  end

  // Link FSM: advances once per received byte and picks the next MISO byte
  always_comb begin
    link_d      = link_q;
    card_d      = card_q;
    app_d       = app_q;
    poll_d      = poll_q;
    ready_d     = ready_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    read_d      = read_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    load_cnt_d  = load_cnt_q;

    if (cs_idle) begin
      link_d = LINK_HUNT;
      tx_d   = FILL_BYTE;
    end else if (rx_valid) begin
      tx_d = FILL_BYTE;
      unique case (link_q)
        LINK_HUNT: begin
          if (rx_byte[7:6] == 2'b01) begin
            link_d = LINK_CMD;
            cmd_d  = rx_byte[5:0];
            cnt_d  = 10'd0;
          end
        end
        LINK_CMD: begin
          if (cnt_q < 10'd4) begin
            arg_d = {arg_q[23:0], rx_byte};
            cnt_d = cnt_q + 10'd1;
          end else begin
            // CRC byte: frame complete, commit card-side effects now
            card_d  = dec.card;
            app_d   = dec.app;
            poll_d  = dec.poll;
            ready_d = dec.ready;
            read_d  = dec.read;
            if (dec.respond) begin
              link_d = LINK_NCR;
              if (dec.r7) begin
                resp_d      = {dec.r1, 8'h00, 8'h00, {4'h0, arg_q[11:8]}, arg_q[7:0]};
                resp_left_d = 3'd4;
              end else begin
                resp_d      = {dec.r1, 32'hFFFF_FFFF};
                resp_left_d = 3'd0;
              end
            end else begin
              link_d = LINK_HUNT;
            end
          end
        end
        LINK_NCR: begin
          link_d = LINK_RESP;
          tx_d   = resp_q[39:32];
          resp_d = {resp_q[31:0], 8'hFF};
        end
        LINK_RESP: begin
          if (resp_left_q != 3'd0) begin
            tx_d        = resp_q[39:32];
            resp_d      = {resp_q[31:0], 8'hFF};
            resp_left_d = resp_left_q - 3'd1;
          end else if (read_q) begin
            addr_d = {arg_q[14:0], 9'd0};
            if (ACCESS_DELAY == 0) begin
              link_d = LINK_TOKEN;
              tx_d   = TOKEN_START;
            end else begin
              link_d = LINK_NAC;
              cnt_d  = 10'd1;
            end
          end else begin
            link_d = LINK_HUNT;
          end
        end
        LINK_NAC: begin
          if (32'(cnt_q) >= ACCESS_DELAY) begin
            link_d = LINK_TOKEN;
            tx_d   = TOKEN_START;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        LINK_TOKEN: begin
          // mem_data already reflects the block base address
          link_d = LINK_DATA;
          tx_d   = bus.mem_data;
          addr_d = addr_q + 24'd1;
          cnt_d  = 10'd0;
        end
        LINK_DATA: begin
          if (32'(cnt_q) == BLOCK_BYTES - 1) begin
            link_d = LINK_CRC;
            tx_d   = CRC_BYTE;
            cnt_d  = 10'd0;
          end else begin
            tx_d   = bus.mem_data;
            addr_d = addr_q + 24'd1;
            cnt_d  = cnt_q + 10'd1;
          end
        end
        LINK_CRC: begin
          if (cnt_q == 10'd0) begin
            tx_d  = CRC_BYTE;
            cnt_d = 10'd1;
          end else begin
            link_d     = LINK_HUNT;
            load_cnt_d = load_cnt_q + 8'd1;
          end
        end
        default: link_d = LINK_HUNT;
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      link_q      <= LINK_HUNT;
      card_q      <= CARD_POWERUP;
      app_q       <= 1'b0;
      poll_q      <= 8'd0;
      ready_q     <= 1'b0;
      cnt_q       <= 10'd0;
      cmd_q       <= 6'd0;
      arg_q       <= 32'd0;
      resp_q      <= 40'hFF_FFFF_FFFF;
      resp_left_q <= 3'd0;
      read_q      <= 1'b0;
      tx_q        <= FILL_BYTE;
      addr_q      <= 24'd0;
      load_cnt_q  <= 8'd0;
    end else begin
      link_q      <= link_d;
      card_q      <= card_d;
      app_q       <= app_d;
      poll_q      <= poll_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      read_q      <= read_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign bus.mem_address = addr_q;
  assign card_ready      = ready_q;
  assign load_count      = load_cnt_q;

endmodule

// File: tb/tb_sd_card_responder.sv
// Bench for sd_card_responder: acts as SPI host and byte-wide memory.
// Each MISO byte slot is queued together with the MOSI byte and the
// expected reply, then shifted out and compared in order.
`timescale 1ns/1ps
module tb_sd_card_responder;

  localparam int HALF = 4;  // clk cycles per SPI clock phase

  logic       clk = 1'b0;
  logic       reset;
  logic       card_ready;
  logic [7:0] load_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp;
  } slot_t;

  slot_t sb_q[$];

  sd_card_responder_if bus();

  sd_card_responder #(
    .INIT_POLLS   (2),
    .ACCESS_DELAY (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .card_ready (card_ready),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  // Backing store: data valid one clk after the address, pattern addr ^ 0x5A
  always @(posedge clk) bus.mem_data <= bus.mem_address[7:0] ^ 8'h5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_slot(input logic [7:0] tx, input logic [7:0] exp);
    slot_t s;
    s.tx  = tx;
    s.exp = exp;
    sb_q.push_back(s);
  endtask

  // Six command bytes; the card answers 0xFF while it is listening
  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    push_slot({2'b01, idx}, 8'hFF);
    for (int i = 3; i >= 0; i--) push_slot(arg[8*i +: 8], 8'hFF);
    push_slot(crc, 8'hFF);
  endtask

  task automatic push_reply(input logic [7:0] exp);
    push_slot(8'hFF, exp);
  endtask

  // NCR, R1 = 0x00, two access-delay fills, start token, then n data bytes
  task automatic push_read_head(input logic [23:0] base, input int n);
    logic [23:0] a;
    push_reply(8'hFF);
    push_reply(8'h00);
    push_reply(8'hFF);
    push_reply(8'hFF);
    push_reply(8'hFE);
    for (int i = 0; i < n; i++) begin
      a = base + 24'(i);
      push_reply(a[7:0] ^ 8'h5A);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bus.spi_di = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = bus.spi_do;
      bus.spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    slot_t      s;
    logic [7:0] rx;
    int         k = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      spi_byte(s.tx, rx);
      check($sformatf("%s slot %0d", tag, k), {24'd0, rx}, {24'd0, s.exp});
      k++;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.spi_cs  = 1'b1;
    bus.spi_clk = 1'b0;
    bus.spi_di  = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset spi_do", {31'd0, bus.spi_do}, 32'd1);
    check("reset mem_address", {8'd0, bus.mem_address}, 32'd0);
    check("reset card_ready", {31'd0, card_ready}, 32'd0);
    check("reset load_count", {24'd0, load_count}, 32'd0);

    bus.spi_cs = 1'b0;
    repeat (8) @(negedge clk);

    // CMD8 before CMD0: no response at all
    push_cmd(6'd8, 32'h0000_01AA, 8'h87);
    for (int i = 0; i < 8; i++) push_reply(8'hFF);
    drain("pre-cmd0 cmd8");

    // CMD0 -> R1 idle in the 2nd slot after the frame
    push_cmd(6'd0, 32'd0, 8'h95);
    push_reply(8'hFF);
    push_reply(8'h01);
    drain("cmd0");

    // CMD8 -> R7 echoes the check pattern
    push_cmd(6'd8, 32'h0000_01AA, 8'h87);
    push_reply(8'hFF);
    push_reply(8'h01);
    push_reply(8'h00);
    push_reply(8'h00);
    push_reply(8'h01);
    push_reply(8'hAA);
    drain("cmd8");

    // ACMD41 polling: first poll still idle, second completes init
    push_cmd(6'd55, 32'd0, 8'h01); push_reply(8'hFF); push_reply(8'h01);
    push_cmd(6'd41, 32'h4000_0000, 8'h01); push_reply(8'hFF); push_reply(8'h01);
    drain("acmd41 poll1");
    check("card_ready after poll1", {31'd0, card_ready}, 32'd0);
    push_cmd(6'd55, 32'd0, 8'h01); push_reply(8'hFF); push_reply(8'h01);
    push_cmd(6'd41, 32'h4000_0000, 8'h01); push_reply(8'hFF); push_reply(8'h00);
    drain("acmd41 poll2");
    check("card_ready after poll2", {31'd0, card_ready}, 32'd1);

    // Full sector read, block 3 -> address 0x600
    push_cmd(6'd17, 32'd3, 8'h01);
    push_read_head(24'h000600, 512);
    push_reply(8'h00);
    push_reply(8'h00);
    push_reply(8'hFF);
    drain("cmd17 blk3");
    check("load_count after blk3", {24'd0, load_count}, 32'd1);

    // Out-of-range argument -> parameter error, no token follows
    push_cmd(6'd17, 32'h0001_0000, 8'h01);
    push_reply(8'hFF);
    push_reply(8'h40);
    for (int i = 0; i < 4; i++) push_reply(8'hFF);
    drain("cmd17 range");

    // CS abort after 100 data bytes leaves load_count alone
    push_cmd(6'd17, 32'd0, 8'h01);
    push_read_head(24'h000000, 100);
    drain("cmd17 abort");
    bus.spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    check("spi_do with cs high", {31'd0, bus.spi_do}, 32'd1);
    check("load_count after abort", {24'd0, load_count}, 32'd1);
    bus.spi_cs = 1'b0;
    repeat (10) @(negedge clk);

    push_cmd(6'd17, 32'd0, 8'h01);
    push_read_head(24'h000000, 512);
    push_reply(8'h00);
    push_reply(8'h00);
    push_reply(8'hFF);
    drain("cmd17 blk0");
    check("load_count after blk0", {24'd0, load_count}, 32'd2);

    // Reset in the middle of a data block
    push_cmd(6'd17, 32'd0, 8'h01);
    push_read_head(24'h000000, 10);
    drain("cmd17 pre-reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid-reset spi_do", {31'd0, bus.spi_do}, 32'd1);
    check("mid-reset card_ready", {31'd0, card_ready}, 32'd0);
    check("mid-reset load_count", {24'd0, load_count}, 32'd0);
    check("mid-reset mem_address", {8'd0, bus.mem_address}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    push_cmd(6'd17, 32'd0, 8'h01);
    for (int i = 0; i < 8; i++) push_reply(8'hFF);
    drain("cmd17 after reset");
    push_cmd(6'd0, 32'd0, 8'h95);
    push_reply(8'hFF);
    push_reply(8'h01);
    drain("cmd0 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
